// File: rtl/alu_sweep_driver.sv
// alu_sweep_driver
//   Drives a 48-vector operand/opcode sweep into an external combinational
//   ALU and folds every result (alu_out ^ apsr) into a 32-bit MISR. At the
//   end of the sweep the signature is compared against a golden value.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      sweep control (abort has priority)
//   seed_a, seed_b    set-0 operands, taken when a sweep is accepted
//   golden            expected final signature, used on the final capture
//   alu_out, apsr     ALU result and status flags
//   alu_a, alu_b      registered ALU operands
//   alu_op            registered ALU opcode
//   busy, done, pass  sweep status
//   signature         MISR accumulator
//   vec_idx           current vector index (set*16 + alu_op)
//
// state | meaning
// IDLE  | waiting for start, ALU outputs parked at 0
// SWEEP | stepping vectors, capturing on the last dwell cycle of each
// DONE  | sweep finished, done/pass/signature held until start or abort

module alu_sweep_driver #(
  parameter int unsigned DWELL     = 1,
  parameter logic [31:0] MISR_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] seed_a,
  input  logic [31:0] seed_b,
  input  logic [31:0] golden,
  input  logic [31:0] alu_out,
  input  logic [31:0] apsr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [5:0]  vec_idx
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [3:0] DWELL_RELOAD = 4'(DWELL - 1);
  localparam logic [5:0] LAST_VEC     = 6'd47;

  state_t      state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        pass_q, pass_d;
  logic [31:0] sig_q, sig_d;
  logic [5:0]  vec_idx_q, vec_idx_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [31:0] sig_step;

  assign sig_step = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]}
                    ^ alu_out ^ apsr;

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    pass_d    = pass_q;
    sig_d     = sig_q;
    vec_idx_d = vec_idx_q;
    dwell_d   = dwell_q;

    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d   = IDLE;
          alu_a_d   = '0;
          alu_b_d   = '0;
          alu_op_d  = '0;
          pass_d    = 1'b0;
          vec_idx_d = '0;
          dwell_d   = '0;
        end else if (start) begin
          state_d   = SWEEP;
          alu_a_d   = seed_a;
          alu_b_d   = seed_b;
          alu_op_d  = '0;
          pass_d    = 1'b0;
          sig_d     = MISR_INIT;
          vec_idx_d = '0;
          dwell_d   = DWELL_RELOAD;
        end
      end

      SWEEP: begin
        if (abort) begin
          // signature deliberately left holding its last value
          state_d   = IDLE;
          alu_a_d   = '0;
          alu_b_d   = '0;
          alu_op_d  = '0;
          pass_d    = 1'b0;
          vec_idx_d = '0;
          dwell_d   = '0;
        end else if (dwell_q == 4'd0) begin
          sig_d   = sig_step;
          dwell_d = DWELL_RELOAD;
          if (vec_idx_q == LAST_VEC) begin
            state_d  = DONE;
            pass_d   = (sig_step == golden);
            alu_a_d  = '0;
            alu_b_d  = '0;
            alu_op_d = '0;
          end else begin
            vec_idx_d = vec_idx_q + 6'd1;
            alu_op_d  = alu_op_q + 4'd1;
            // opcode wrap moves to the next operand set: set 1 is all-zero,
            // set 2 is all-ones
            if (alu_op_q == 4'hF) begin
              if (vec_idx_q[5:4] == 2'd0) begin
                alu_a_d = '0;
                alu_b_d = '0;
              end else begin
                alu_a_d = '1;
                alu_b_d = '1;
              end
            end
          end
        end else begin
          dwell_d = dwell_q - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      pass_q    <= 1'b0;
      sig_q     <= '0;
      vec_idx_q <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      pass_q    <= pass_d;
      sig_q     <= sig_d;
      vec_idx_q <= vec_idx_d;
      dwell_q   <= dwell_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign busy      = (state_q == SWEEP);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Bench for alu_sweep_driver: two instances (DWELL=1 with MISR_INIT=0, and
// DWELL=3 with a non-zero MISR_INIT) driven by a stub ALU. Expected
// per-capture signatures are queued when a sweep is issued; a monitor per
// instance pops and compares them as the DUT presents captures and done.

module tb_alu_sweep_driver;

  localparam logic [31:0] INIT0 = 32'h0000_0000;
  localparam logic [31:0] INIT1 = 32'hA5A5_0F0F;

  logic clk;
  logic rst_n;
  logic [1:0]       start, abort, busy, done, pass;
  logic [1:0][31:0] seed_a, seed_b, golden, alu_out, apsr;
  logic [1:0][31:0] alu_a, alu_b, signature;
  logic [1:0][3:0]  alu_op;
  logic [1:0][5:0]  vec_idx;
  int               mode [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_sig_q  [2][$];
  logic        exp_pass_q [2][$];
  logic [31:0] cur_sa [2];
  logic [31:0] cur_sb [2];

  alu_sweep_driver #(.DWELL(1), .MISR_INIT(INIT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .seed_a(seed_a[0]), .seed_b(seed_b[0]), .golden(golden[0]),
    .alu_out(alu_out[0]), .apsr(apsr[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_op(alu_op[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .signature(signature[0]), .vec_idx(vec_idx[0]));

  alu_sweep_driver #(.DWELL(3), .MISR_INIT(INIT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .seed_a(seed_a[1]), .seed_b(seed_b[1]), .golden(golden[1]),
    .alu_out(alu_out[1]), .apsr(apsr[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_op(alu_op[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .signature(signature[1]), .vec_idx(vec_idx[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dw(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_of(int d);
    return (d == 0) ? INIT0 : INIT1;
  endfunction

  function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return b - a;
      4'd9:    return a + 32'd1;
      4'd10:   return ~(a & b);
      4'd11:   return ~(a | b);
      4'd12:   return {a[15:0], b[15:0]};
      4'd13:   return a * b;
      4'd14:   return a - 32'd1;
      default: return $unsigned($signed(a) >>> b[4:0]);
    endcase
  endfunction

  function automatic logic [31:0] stub_out(logic [31:0] a, logic [31:0] b,
                                           logic [3:0] op, logic [5:0] idx, int md);
    if (md == 0) return 32'd0;
    if (md == 1) return (idx == 6'd0) ? 32'd1 : 32'd0;
    return alu_ref(a, b, op);
  endfunction

  function automatic logic [31:0] stub_flags(logic [31:0] a, logic [31:0] b,
                                             logic [3:0] op, int md);
    logic [31:0] r;
    if (md < 2) return 32'd0;
    r = alu_ref(a, b, op);
    return {(r == 32'd0), r[31], 26'd0, op};
  endfunction

  function automatic logic [31:0] vec_operand(int idx, logic [31:0] seed);
    if (idx < 16) return seed;
    if (idx < 32) return 32'd0;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub ALU and monitor, one per instance
  for (genvar g = 0; g < 2; g++) begin : g_env
    assign alu_out[g] = stub_out(alu_a[g], alu_b[g], alu_op[g], vec_idx[g], mode[g]);
    assign apsr[g]    = stub_flags(alu_a[g], alu_b[g], alu_op[g], mode[g]);

    int          cnt = 0;
    logic        pbusy = 1'b0;
    logic [5:0]  pidx = '0;
    logic [31:0] last_sig = '0;

    always @(negedge clk) begin
      if (!rst_n) begin
        exp_sig_q[g].delete();
        exp_pass_q[g].delete();
        cnt   = 0;
        pbusy = 1'b0;
        pidx  = '0;
      end else begin
        if (busy[g]) begin
          int idx;
          cnt++;
          if (!pbusy) begin
            chk($sformatf("d%0d_sig_init", g), signature[g], init_of(g));
          end else if (vec_idx[g] != pidx) begin
            if (exp_sig_q[g].size() == 0)
              chk($sformatf("d%0d_capture_unexpected", g), 32'd1, 32'd0);
            else
              chk($sformatf("d%0d_sig_capture", g), signature[g], exp_sig_q[g].pop_front());
          end
          idx = (cnt - 1) / dw(g);
          if (idx > 47) idx = 47;
          chk($sformatf("d%0d_vec_idx", g), 32'(vec_idx[g]), 32'(idx));
          chk($sformatf("d%0d_alu_op", g), 32'(alu_op[g]), 32'(idx % 16));
          chk($sformatf("d%0d_alu_a", g), alu_a[g], vec_operand(idx, cur_sa[g]));
          chk($sformatf("d%0d_alu_b", g), alu_b[g], vec_operand(idx, cur_sb[g]));
        end else if (pbusy) begin
          if (done[g]) begin
            if (exp_sig_q[g].size() != 1 || exp_pass_q[g].size() != 1) begin
              chk($sformatf("d%0d_done_queue_depth", g), 32'(exp_sig_q[g].size()), 32'd1);
            end else begin
              chk($sformatf("d%0d_sig_final", g), signature[g], exp_sig_q[g].pop_front());
              chk($sformatf("d%0d_pass", g), 32'(pass[g]), 32'(exp_pass_q[g].pop_front()));
            end
            chk($sformatf("d%0d_busy_len", g), 32'(cnt), 32'(48 * dw(g)));
            chk($sformatf("d%0d_done_alu_zero", g), alu_a[g] | alu_b[g] | 32'(alu_op[g]), 32'd0);
          end else begin
            chk($sformatf("d%0d_abort_sig_hold", g), signature[g], last_sig);
            chk($sformatf("d%0d_abort_flags", g), {30'd0, done[g], pass[g]}, 32'd0);
            chk($sformatf("d%0d_abort_outs", g),
                alu_a[g] | alu_b[g] | 32'(alu_op[g]) | 32'(vec_idx[g]), 32'd0);
            exp_sig_q[g].delete();
            exp_pass_q[g].delete();
          end
          cnt = 0;
        end
        pbusy    = busy[g];
        pidx     = vec_idx[g];
        last_sig = signature[g];
      end
    end
  end

  // Computes the expected capture sequence, queues it, and pulses start.
  // golden is first driven wrong and corrected mid-sweep.
  task automatic start_sweep(input int d, input logic [31:0] sa, input logic [31:0] sb,
                             input int md, input bit good,
                             output logic [31:0] final_sig, output logic exp_pass);
    logic [31:0] sig, a, b, fb, gold;
    sig = init_of(d);
    for (int i = 0; i < 48; i++) begin
      a  = vec_operand(i, sa);
      b  = vec_operand(i, sb);
      fb = {31'd0, sig[31] ^ sig[21] ^ sig[1] ^ sig[0]};
      sig = ((sig << 1) | fb) ^ stub_out(a, b, 4'(i % 16), 6'(i), md)
            ^ stub_flags(a, b, 4'(i % 16), md);
      exp_sig_q[d].push_back(sig);
    end
    gold = good ? sig : (sig ^ 32'h0000_0001);
    exp_pass_q[d].push_back(good);
    final_sig = sig;
    exp_pass  = good;
    @(posedge clk); #1;
    mode[d]   = md;
    seed_a[d] = sa;
    seed_b[d] = sb;
    cur_sa[d] = sa;
    cur_sb[d] = sb;
    golden[d] = gold ^ 32'h8000_0000;
    start[d]  = 1'b1;
    @(posedge clk); #1;
    start[d]  = 1'b0;
    seed_a[d] = $urandom;
    seed_b[d] = $urandom;
    repeat (4) @(posedge clk);
    #1 golden[d] = gold;
  endtask

  task automatic wait_done(input int d);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done[d]) begin
        seen = 1;
        break;
      end
    end
    chk($sformatf("d%0d_done_timeout", d), 32'(seen), 32'd1);
  endtask

  task automatic run_full(input int d, input logic [31:0] sa, input logic [31:0] sb,
                          input int md, input bit good);
    logic [31:0] fs;
    logic        ep;
    start_sweep(d, sa, sb, md, good, fs, ep);
    wait_done(d);
    repeat (3) @(negedge clk);
    chk($sformatf("d%0d_done_hold", d), 32'(done[d]), 32'd1);
    chk($sformatf("d%0d_pass_hold", d), 32'(pass[d]), 32'(ep));
    chk($sformatf("d%0d_sig_hold", d), signature[d], fs);
  endtask

  task automatic chk_all_zero(input int d, input string tag);
    chk($sformatf("d%0d_%s_ops", d, tag), alu_a[d] | alu_b[d] | 32'(alu_op[d]), 32'd0);
    chk($sformatf("d%0d_%s_flags", d, tag), {29'd0, busy[d], done[d], pass[d]}, 32'd0);
    chk($sformatf("d%0d_%s_sig", d, tag), signature[d], 32'd0);
    chk($sformatf("d%0d_%s_idx", d, tag), 32'(vec_idx[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fs;
    logic        ep;
    bit          seen;
    rst_n  = 1'b0;
    start  = '0;
    abort  = '0;
    seed_a = '0;
    seed_b = '0;
    golden = '0;
    mode[0] = 0;
    mode[1] = 0;
    cur_sa[0] = '0; cur_sa[1] = '0;
    cur_sb[0] = '0; cur_sb[1] = '0;
    #12;
    chk_all_zero(0, "reset");
    chk_all_zero(1, "reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // zero ALU: pass with golden 0, fail with golden 1 (restart from DONE)
    run_full(0, 32'h0A, 32'h02, 0, 1'b1);
    run_full(0, 32'h0A, 32'h02, 0, 1'b0);
    // single injected 1 at vector 0
    run_full(0, $urandom, $urandom, 1, 1'b1);
    // real ALU, random operands
    for (int k = 0; k < 3; k++) run_full(0, $urandom, $urandom, 2, 1'($urandom_range(0, 1)));
    // DWELL=3 instance, non-zero MISR_INIT
    run_full(1, $urandom, $urandom, 2, 1'b1);
    run_full(1, 32'h0A, 32'h02, 0, 1'b0);

    // abort from DONE clears done/pass
    @(posedge clk); #1 abort[1] = 1'b1;
    @(posedge clk); #1 abort[1] = 1'b0;
    @(negedge clk);
    chk("d1_done_abort_flags", {29'd0, busy[1], done[1], pass[1]}, 32'd0);

    // ignored start mid-sweep, then abort
    start_sweep(0, $urandom, $urandom, 2, 1'b1, fs, ep);
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    @(negedge clk);
    chk("d0_after_abort_busy", 32'(busy[0]), 32'd0);
    // start together with abort in IDLE stays idle
    @(posedge clk); #1 begin start[0] = 1'b1; abort[0] = 1'b1; end
    @(posedge clk); #1 begin start[0] = 1'b0; abort[0] = 1'b0; end
    @(negedge clk);
    chk("d0_start_abort_idle", {30'd0, busy[0], done[0]}, 32'd0);

    // asynchronous reset mid-sweep at vector 20
    start_sweep(0, $urandom, $urandom, 2, 1'b1, fs, ep);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vec_idx[0] == 6'd20) begin
        seen = 1;
        break;
      end
    end
    chk("d0_reach_idx20", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero(0, "async_reset");
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("d0_idle_after_reset", 32'(busy[0]), 32'd0);
    run_full(0, $urandom, $urandom, 2, 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
